// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the systolic FIR chain and its
// output collector (default widths, tap count, unity coefficients, sample type).
// No ports; imported with fir_pkg::*.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_TAPS   = 4;

  // Unity coefficients: each PE passes its product through unscaled.
  localparam logic [7:0] FIR_COEF [FIR_TAPS] = '{8'h01, 8'h01, 8'h01, 8'h01};

  typedef logic [FIR_DATA_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_coll_fifo.sv
// fir_coll_fifo: DEPTH x DATA_W synchronous first-word-fall-through FIFO.
// Ports: clk, reset (sync active-low), flush (sync clear), wr_en/wr_data,
//   rd_en (pop head), rd_data (head, 0 when empty), count, full, empty.
// Caller guarantees rd_en only when !empty and wr_en only when !full or rd_en.
module fir_coll_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = FIR_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the natural rollover the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; rd_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign count   = r_count;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_out_collector.sv
// fir_out_collector: receive end of the systolic FIR chain. Samples fir_y
// LATENCY cycles after each in_valid, drops the TAPS-1 partial-window results
// after reset/flush, keeps 1 of every DECIM primed samples, buffers in a FIFO.
// Ports: clk, reset (sync active-low), flush (sync clear), in_valid, fir_y,
//   out_data/out_valid/out_ready (FWFT valid-ready), count, primed,
//   overflow (sticky drop flag). The FIR cannot stall: a kept sample that
//   meets a full FIFO with no pop is dropped.
// Option: define FIR_COLL_DROPCNT_EN to add drop_cnt[7:0], a saturating
//   count of dropped samples.
module fir_out_collector
  import fir_pkg::*;
#(
  parameter int DATA_W  = FIR_DATA_W,
  parameter int TAPS    = FIR_TAPS,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int DECIM   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        fir_y,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     primed,
`ifdef FIR_COLL_DROPCNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic                     overflow
);

  localparam int DW = $clog2(TAPS) + 1;
  localparam logic [DW-1:0] DISC_MAX = DW'(TAPS - 1);
  localparam logic [7:0]    DEC_MAX  = 8'(DECIM - 1);

  logic [LATENCY-1:0] r_pipe;
  logic [DW-1:0]      r_disc;
  logic [7:0]         r_dec;
  logic               r_ovf;

  logic w_clr;
  logic w_dv;
  logic w_keep;
  logic w_pop;
  logic w_wr;
  logic w_drop;
  logic w_full;
  logic w_empty;

  assign w_clr = !reset || flush;

  // in_valid delay line: the tap marks the cycle fir_y carries the result
  // for that input sample.
  if (LATENCY == 1) begin : g_pipe1
    always_ff @(posedge clk) begin
      if (w_clr) r_pipe <= '0;
      else       r_pipe <= in_valid;
    end
  end else begin : g_pipen
    always_ff @(posedge clk) begin
      if (w_clr) r_pipe <= '0;
      else       r_pipe <= {r_pipe[LATENCY-2:0], in_valid};
    end
  end

  assign w_dv   = r_pipe[LATENCY-1];
  assign primed = (r_disc == DISC_MAX);

  // First primed sample is always kept because r_dec starts at zero.
  assign w_keep = w_dv && primed && (r_dec == '0);
  assign w_pop  = out_valid && out_ready;
  assign w_wr   = w_keep && (!w_full || w_pop);
  assign w_drop = w_keep && !w_wr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_disc <= '0;
      r_dec  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_dv && !primed) r_disc <= r_disc + 1'b1;
      if (w_dv && primed)  r_dec  <= (r_dec == DEC_MAX) ? 8'd0 : r_dec + 8'd1;
      if (w_drop)          r_ovf  <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign out_valid = !w_empty;

`ifdef FIR_COLL_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_clr)                         r_drop_cnt <= '0;
    else if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

  fir_coll_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (w_wr),
    .wr_data (fir_y),
    .rd_en   (w_pop),
    .rd_data (out_data),
    .count   (count),
    .full    (w_full),
    .empty   (w_empty)
  );

endmodule

// File: tb/tb_fir_out_collector.sv
// Bench for fir_out_collector: two instances (DECIM=1 and DECIM=3) share one
// stimulus stream; a queue-based reference model predicts every output.
module tb_fir_out_collector;
  import fir_pkg::*;

  localparam int TAPS  = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] fir_y;

  logic [15:0] od0, od1;
  logic        ov0, ov1;
  logic [3:0]  cnt0, cnt1;
  logic        pr0, pr1;
  logic        of0, of1;
`ifdef FIR_COLL_DROPCNT_EN
  logic [7:0]  drop0, drop1;
`endif

  logic [22:0] got0, got1;
  assign got0 = {ov0, cnt0, pr0, of0, od0};
  assign got1 = {ov1, cnt1, pr1, of1, od1};

  int n_vec = 0;
  int n_err = 0;

  fir_out_collector #(.DATA_W(16), .TAPS(TAPS), .LATENCY(LAT), .DEPTH(DEPTH), .DECIM(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .fir_y(fir_y),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .count(cnt0),
    .primed(pr0),
`ifdef FIR_COLL_DROPCNT_EN
    .drop_cnt(drop0),
`endif
    .overflow(of0)
  );

  fir_out_collector #(.DATA_W(16), .TAPS(TAPS), .LATENCY(LAT), .DEPTH(DEPTH), .DECIM(3)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .fir_y(fir_y),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .count(cnt1),
    .primed(pr1),
`ifdef FIR_COLL_DROPCNT_EN
    .drop_cnt(drop1),
`endif
    .overflow(of1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // pend holds the cycle numbers at which a result is due on fir_y; ndv counts
  // results seen since the last clear; mq[k] is the FIFO content of instance k.
  int          pend[$];
  int          ndv = 0;
  int          cyc = 0;
  fir_sample_t mq[2][$];
  bit          movf[2];
  int          mdrop[2];

  function automatic int decim_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin : model
    bit dv;
    bit pop;
    bit keep;
    if (!reset || flush) begin
      pend.delete();
      ndv = 0;
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        movf[k]  = 1'b0;
        mdrop[k] = 0;
      end
    end else begin
      dv = (pend.size() > 0) && (pend[0] == cyc);
      if (dv) void'(pend.pop_front());
      if (in_valid) pend.push_back(cyc + LAT);
      for (int k = 0; k < 2; k++) begin
        pop  = (mq[k].size() > 0) && out_ready;
        keep = dv && (ndv >= TAPS - 1) && (((ndv - (TAPS - 1)) % decim_of(k)) == 0);
        if (pop) void'(mq[k].pop_front());
        if (keep) begin
          if (mq[k].size() < DEPTH) mq[k].push_back(fir_y);
          else begin
            movf[k] = 1'b1;
            if (mdrop[k] < 255) mdrop[k]++;
          end
        end
      end
      if (dv) ndv++;
    end
    cyc++;
  end

  function automatic logic [22:0] exp_vec(int k);
    logic [15:0] hd;
    hd = '0;
    if (mq[k].size() > 0) hd = mq[k][0];
    return {mq[k].size() > 0, 4'(mq[k].size()), ndv >= TAPS - 1, movf[k], hd};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; fir_y = 16'(i + 5);
      @(negedge clk);
      n_vec++;
      if (got0 !== 23'h0) begin n_err++; $display("FAIL reset d1 cyc %0d: got %h want 0", i, got0); end
      n_vec++;
      if (got1 !== 23'h0) begin n_err++; $display("FAIL reset d3 cyc %0d: got %h want 0", i, got1); end
    end
  endtask

  task automatic test_prime_stream;
    int o;
    for (int c = 0; c < 24; c++) begin
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; fir_y = 16'(c);
      @(negedge clk);
      o = c + 1;
      n_vec++;
      if (got0 !== exp_vec(0)) begin n_err++; $display("FAIL prime model d1 cyc %0d: got %h want %h", o, got0, exp_vec(0)); end
      n_vec++;
      if (got1 !== exp_vec(1)) begin n_err++; $display("FAIL prime model d3 cyc %0d: got %h want %h", o, got1, exp_vec(1)); end
      if (o == 6) begin
        n_vec++;
        if (pr0 !== 1'b0) begin n_err++; $display("FAIL prime early cyc 6: primed=%b want 0", pr0); end
      end
      if (o == 7) begin
        n_vec++;
        if (pr0 !== 1'b1 || ov0 !== 1'b0) begin n_err++; $display("FAIL prime cyc 7: primed=%b out_valid=%b want 1 0", pr0, ov0); end
      end
      if (o == 8) begin
        n_vec++;
        if (ov0 !== 1'b1 || od0 !== 16'd7) begin n_err++; $display("FAIL first out cyc 8: valid=%b data=%0d want 1 7", ov0, od0); end
      end
      if (o == 9) begin
        n_vec++;
        if (od0 !== 16'd8) begin n_err++; $display("FAIL second out cyc 9: data=%0d want 8", od0); end
      end
    end
  endtask

  task automatic test_overflow;
    int o;
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 28; c++) begin
      reset = 1'b1; in_valid = (c < 20); out_ready = 1'b0; fir_y = 16'(c);
      @(negedge clk);
      o = c + 1;
      n_vec++;
      if (got0 !== exp_vec(0)) begin n_err++; $display("FAIL ovf model d1 cyc %0d: got %h want %h", o, got0, exp_vec(0)); end
      n_vec++;
      if (got1 !== exp_vec(1)) begin n_err++; $display("FAIL ovf model d3 cyc %0d: got %h want %h", o, got1, exp_vec(1)); end
      if (o == 15) begin
        n_vec++;
        if (of0 !== 1'b0) begin n_err++; $display("FAIL ovf early cyc 15: overflow=%b want 0", of0); end
      end
      if (o == 16) begin
        n_vec++;
        if (of0 !== 1'b1) begin n_err++; $display("FAIL ovf set cyc 16: overflow=%b want 1", of0); end
      end
    end
    n_vec++;
    if (cnt0 !== 4'd8 || od0 !== 16'd7) begin n_err++; $display("FAIL ovf final: count=%0d head=%0d want 8 7", cnt0, od0); end
`ifdef FIR_COLL_DROPCNT_EN
    n_vec++;
    if (drop0 !== 8'd9) begin n_err++; $display("FAIL drop_cnt: got %0d want 9", drop0); end
`endif
  endtask

  task automatic test_full_passthru;
    int o;
    logic [15:0] prev;
    prev = '0;
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; out_ready = (c >= 15); fir_y = 16'(c);
      @(negedge clk);
      o = c + 1;
      n_vec++;
      if (got0 !== exp_vec(0)) begin n_err++; $display("FAIL full model d1 cyc %0d: got %h want %h", o, got0, exp_vec(0)); end
      if (o == 15) begin
        n_vec++;
        if (cnt0 !== 4'd8 || of0 !== 1'b0) begin n_err++; $display("FAIL full fill: count=%0d ovf=%b want 8 0", cnt0, of0); end
      end
      if (o >= 16) begin
        n_vec++;
        if (cnt0 !== 4'd8 || of0 !== 1'b0 || od0 !== 16'(prev + 16'd1)) begin
          n_err++;
          $display("FAIL full pass cyc %0d: count=%0d ovf=%b data=%0d want 8 0 %0d", o, cnt0, of0, od0, 16'(prev + 16'd1));
        end
      end
      prev = od0;
    end
  endtask

  task automatic test_flush;
    int o;
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; fir_y = 16'($urandom);
    @(negedge clk);
    n_vec++;
    if (ov0 !== 1'b0 || cnt0 !== 4'd0 || pr0 !== 1'b0 || of0 !== 1'b0) begin
      n_err++;
      $display("FAIL flush clear: valid=%b count=%0d primed=%b ovf=%b want 0 0 0 0", ov0, cnt0, pr0, of0);
    end
    flush = 1'b0;
    for (int c = 0; c < 14; c++) begin
      in_valid = 1'b1; out_ready = 1'b1; fir_y = 16'($urandom);
      @(negedge clk);
      o = c + 1;
      n_vec++;
      if (got0 !== exp_vec(0)) begin n_err++; $display("FAIL flush model d1 cyc %0d: got %h want %h", o, got0, exp_vec(0)); end
      if (o == 6 || o == 8) begin
        n_vec++;
        if (ov0 !== (o == 8) || pr0 !== 1'b1 && o == 8) begin
          n_err++;
          $display("FAIL flush reprime cyc %0d: valid=%b primed=%b", o, ov0, pr0);
        end
      end
    end
  endtask

  task automatic test_decim;
    int o;
    fir_sample_t cap[$];
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      reset = 1'b1; in_valid = (c < 15); out_ready = 1'b1; fir_y = 16'(93 + c);
      @(negedge clk);
      o = c + 1;
      if (ov1) cap.push_back(od1);
      n_vec++;
      if (got1 !== exp_vec(1)) begin n_err++; $display("FAIL decim model d3 cyc %0d: got %h want %h", o, got1, exp_vec(1)); end
    end
    n_vec++;
    if (cap.size() != 4) begin n_err++; $display("FAIL decim count: got %0d outputs want 4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= cap.size() || cap[i] !== 16'(100 + 3 * i)) begin
        n_err++;
        $display("FAIL decim value %0d: got %0d want %0d", i, (i < cap.size()) ? cap[i] : 16'hFFFF, 100 + 3 * i);
      end
    end
    // fill both FIFOs mid-burst, then reset
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; out_ready = 1'b0; fir_y = 16'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (got0 !== 23'h0) begin n_err++; $display("FAIL midreset d1: got %h want 0", got0); end
    n_vec++;
    if (got1 !== 23'h0) begin n_err++; $display("FAIL midreset d3: got %h want 0", got1); end
    reset = 1'b1;
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      fir_y     = 16'($urandom);
      @(negedge clk);
      n_vec++;
      if (got0 !== exp_vec(0)) begin n_err++; $display("FAIL rand d1 cyc %0d: got %h want %h", c, got0, exp_vec(0)); end
      n_vec++;
      if (got1 !== exp_vec(1)) begin n_err++; $display("FAIL rand d3 cyc %0d: got %h want %h", c, got1, exp_vec(1)); end
`ifdef FIR_COLL_DROPCNT_EN
      n_vec++;
      if (drop0 !== 8'(mdrop[0]) || drop1 !== 8'(mdrop[1])) begin
        n_err++;
        $display("FAIL rand drop_cnt cyc %0d: got %0d %0d want %0d %0d", c, drop0, drop1, mdrop[0], mdrop[1]);
      end
`endif
    end
    flush = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; fir_y = '0;
    @(negedge clk);
    test_reset();
    test_prime_stream();
    test_overflow();
    test_full_passthru();
    test_flush();
    test_decim();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
